bcd_display_scanner: RTL and testbench



---
 rtl/bcd_display_scanner.sv | 134 +++++++++++++
 tb/tb_bcd_display_scanner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a time-multiplexed digit bus.
// Optional macro LEADING_ZERO_BLANK_EN drives 4'hF on leading-zero digits (digit 0 never blanked).
//
// state     | meaning
// ST_IDLE   | bin_ready high, waiting for bin_valid
// ST_SHIFT  | BIN_W double-dabble shift cycles
// ST_COMMIT | copy BCD result to committed digits, pulse conv_done
module bcd_display_scanner #(
    parameter int BIN_W      = 14,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  bin_valid,
    output logic                  bin_ready,
    output logic                  conv_done,
    output logic                  ovf,
    output logic [3:0]            digit_value,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int unsigned      MAX_VAL = pow10(NUM_DIGITS) - 1;
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);
    localparam int SH_W  = $clog2(BIN_W + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

    state_t                     state;
    logic [BIN_W-1:0]           bin_sr;
    logic [NUM_DIGITS-1:0][3:0] bcd_sr;
    logic [NUM_DIGITS-1:0][3:0] bcd_adj;
    logic [NUM_DIGITS-1:0][3:0] committed;
    logic [SH_W-1:0]            sh_cnt;
    logic                       sat;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj[i] = (bcd_sr[i] >= 4'd5) ? bcd_sr[i] + 4'd3 : bcd_sr[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            sh_cnt    <= '0;
            sat       <= 1'b0;
            committed <= '0;
            bin_ready <= 1'b1;
            conv_done <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bin_valid && bin_ready) begin
                        bin_sr    <= (bin_in > MAX_BIN) ? MAX_BIN : bin_in;
                        sat       <= (bin_in > MAX_BIN);
                        bcd_sr    <= '0;
                        sh_cnt    <= '0;
                        bin_ready <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    sh_cnt           <= sh_cnt + SH_W'(1);
                    if (sh_cnt == SH_W'(BIN_W - 1)) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    committed <= bcd_sr;
                    ovf       <= sat;
                    conv_done <= 1'b1;
                    bin_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Scanner free-runs; new digits only reach the bus at a scan-index advance.
    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [3:0]       nxt_val;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_above;
`endif

    always_comb begin
        nxt_idx = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        nxt_val = committed[nxt_idx];
`ifdef LEADING_ZERO_BLANK_EN
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (committed[i] == 4'd0);
            blank[i]   = zero_above;
        end
        if (blank[nxt_idx]) nxt_val = 4'hF;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt    <= '0;
            scan_idx    <= '0;
            digit_sel   <= ~NUM_DIGITS'(1);
            digit_value <= 4'd0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt    <= '0;
            scan_idx    <= nxt_idx;
            digit_sel   <= ~(NUM_DIGITS'(1) << nxt_idx);
            digit_value <= nxt_val;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: vector table, corner sequences, random values vs arithmetic model.
module tb_bcd_display_scanner;
    localparam int BIN_W = 14;
    localparam int ND    = 4;
    localparam int SD    = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             bin_valid = 1'b0;
    logic             bin_ready, conv_done, ovf;
    logic [3:0]       digit_value;
    logic [ND-1:0]    digit_sel;

    int total = 0;
    int bad   = 0;

    bcd_display_scanner #(.BIN_W(BIN_W), .NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_valid(bin_valid),
        .bin_ready(bin_ready), .conv_done(conv_done), .ovf(ovf),
        .digit_value(digit_value), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int unsigned val;
        logic [15:0] plain;
        logic [15:0] blank;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected digit word straight from decimal arithmetic on the saturated value.
    function automatic logic [15:0] ref_word(input int unsigned v);
        int unsigned s;
        logic [15:0] w;
        s = (v > 9999) ? 9999 : v;
        w = '0;
        for (int i = 0; i < ND; i++) begin
            w[4*i +: 4] = 4'((s / (10 ** i)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && s < 10 ** i) w[4*i +: 4] = 4'hF;
`endif
        end
        return w;
    endfunction

    task automatic show_check(input string name, input logic [15:0] expw);
        logic [3:0] seen [ND];
        int badsel;
        int hit;
        badsel = 0;
        for (int i = 0; i < ND; i++) seen[i] = 4'bxxxx;
        repeat (ND * SD) step();
        repeat (ND * SD) begin
            step();
            hit = -1;
            for (int i = 0; i < ND; i++) if (digit_sel == ~(ND'(1) << i)) hit = i;
            if (hit < 0) badsel++;
            else seen[hit] = digit_value;
        end
        check($sformatf("%s sel_onehot", name), badsel, 0);
        for (int i = 0; i < ND; i++)
            check($sformatf("%s digit%0d", name, i), seen[i], expw[4*i +: 4]);
    endtask

    task automatic convert(input string name, input int unsigned val, input logic exp_ovf,
                           input logic [15:0] expw);
        int k;
        int low;
        check($sformatf("%s ready_before", name), bin_ready, 1);
        bin_in    = BIN_W'(val);
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        k   = 0;
        low = 0;
        while (!conv_done && k < 60) begin
            if (!bin_ready) low++;
            step();
            k++;
        end
        check($sformatf("%s latency", name), k, BIN_W + 1);
        check($sformatf("%s busy_cycles", name), low, BIN_W + 1);
        check($sformatf("%s ovf", name), ovf, exp_ovf);
        step();
        check($sformatf("%s done_single", name), conv_done, 0);
        show_check(name, expw);
    endtask

    vec_t vecs [10];
    int   k, k2, first, second, pulses;
    logic rdy_after;
    int unsigned v;

    initial begin
        vecs[0] = '{1234,  16'h1234, 16'h1234, 1'b0};
        vecs[1] = '{12000, 16'h9999, 16'h9999, 1'b1};
        vecs[2] = '{5,     16'h0005, 16'hFFF5, 1'b0};
        vecs[3] = '{7,     16'h0007, 16'hFFF7, 1'b0};
        vecs[4] = '{0,     16'h0000, 16'hFFF0, 1'b0};
        vecs[5] = '{1005,  16'h1005, 16'h1005, 1'b0};
        vecs[6] = '{9999,  16'h9999, 16'h9999, 1'b0};
        vecs[7] = '{100,   16'h0100, 16'hF100, 1'b0};
        vecs[8] = '{16383, 16'h9999, 16'h9999, 1'b1};
        vecs[9] = '{10000, 16'h9999, 16'h9999, 1'b1};

        // reset state and first scan advances
        repeat (3) step();
        check("rst ready", bin_ready, 1);
        check("rst done", conv_done, 0);
        check("rst ovf", ovf, 0);
        check("rst sel", digit_sel, 4'b1110);
        check("rst value", digit_value, 0);
        rst_n = 1'b1;
        k = 0;
        while (digit_sel == 4'b1110 && k < 100) begin step(); k++; end
        check("rst first_dwell", k, SD);
        check("rst sel1", digit_sel, 4'b1101);
`ifdef LEADING_ZERO_BLANK_EN
        check("rst value1", digit_value, 4'hF);
`else
        check("rst value1", digit_value, 0);
`endif
        k2 = 0;
        while (digit_sel == 4'b1101 && k2 < 100) begin step(); k2++; end
        check("rst second_dwell", k2, SD);
        check("rst sel2", digit_sel, 4'b1011);

        for (int i = 0; i < 10; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            convert($sformatf("vec%0d", i), vecs[i].val, vecs[i].ovf, vecs[i].blank);
`else
            convert($sformatf("vec%0d", i), vecs[i].val, vecs[i].ovf, vecs[i].plain);
`endif
        end

        // reset during SHIFT discards the conversion and the displayed 9999
        bin_in    = BIN_W'(1234);
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("midrst ready", bin_ready, 1);
        check("midrst done", conv_done, 0);
        check("midrst ovf", ovf, 0);
        check("midrst sel", digit_sel, 4'b1110);
        check("midrst value", digit_value, 0);
        step();
        step();
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin step(); if (conv_done) pulses++; end
        check("midrst no_done", pulses, 0);
        show_check("midrst", ref_word(0));

        // bin_valid held while busy: second value taken only on the conv_done cycle
        bin_in    = BIN_W'(1234);
        bin_valid = 1'b1;
        step();
        bin_in    = BIN_W'(42);
        first     = -1;
        second    = -1;
        pulses    = 0;
        rdy_after = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (conv_done) begin
                pulses++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (first >= 0 && i == first + 1) begin
                rdy_after = bin_ready;
                bin_valid = 1'b0;
            end
            step();
        end
        bin_valid = 1'b0;
        check("busy first_done", first, BIN_W + 1);
        check("busy accepted_on_done", rdy_after, 0);
        check("busy second_done", second, 2 * (BIN_W + 1) + 1);
        check("busy pulses", pulses, 2);
        check("busy ovf", ovf, 0);
        show_check("busy", ref_word(42));

        for (int i = 0; i < 15; i++) begin
            v = (i % 3 == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 9999);
            convert($sformatf("rnd%0d", i), v, (v > 9999), ref_word(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
